seq_mac: RTL and testbench
==========================

SEQ_MAC -- requirements
Module: seq_mac

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; even, 8..32.
REQ-002 SHALL have derived localparam STEPS = WIDTH/2+1, the radix-4 iteration count.
REQ-003 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operands and mode valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a_i  input  WIDTH  multiplicand.
REQ-008 SHALL have port b_i  input  WIDTH  multiplier.
REQ-009 SHALL have port mode_i  input  2  00 unsigned×unsigned, 01 signed a × unsigned b, 10 signed×signed, 11 reserved (treated as 10).
REQ-010 SHALL have port acc_i  input  1  add the product to the running accumulator (valid only with SEQ_MAC_ACC_EN).
REQ-011 SHALL have port acc_clr  input  1  clear the accumulator.
REQ-012 SHALL have port result_o  output  2*WIDTH  product or accumulated sum.
REQ-013 SHALL have port out_valid  output  1  result_o valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result.
REQ-015 SHALL have port busy  output  1  high in BUSY state.

Function
REQ-016 SHALL implement FSM IDLE→BUSY on in_valid&&in_ready, BUSY→DONE after STEPS iteration cycles, DONE→IDLE on out_ready.
REQ-017 SHALL drive in_ready high only in IDLE, and out_valid high only in DONE.
REQ-018 SHALL latch a_i, b_i, mode_i, acc_i on acceptance; later input changes SHALL have no effect.
REQ-019 SHALL extend b by 2 bits (sign if signed, zero if unsigned), and a by 2 bits likewise, then retire one radix-4 Booth digit (−2a..+2a) per BUSY cycle, LSB first.
REQ-020 SHALL produce the exact 2*WIDTH-bit product for all modes, including the most-negative operand (no missing sign-bit step).
REQ-021 SHALL have fixed latency: out_valid rises exactly STEPS+1 cycles after the accepting edge.
REQ-022 SHALL hold result_o and out_valid stable in DONE until out_ready; back-to-back acceptance SHALL be possible one cycle after DONE exits.
REQ-023 SHALL, when acc_i latched high, set result = accumulator + product, modulo 2^(2*WIDTH), and update the accumulator with it; otherwise result = product and the accumulator is unchanged.
REQ-024 SHALL zero the accumulator on acc_clr in any state; acc_clr with acceptance in the same cycle SHALL accumulate onto zero.
REQ-025 SHALL hold result_o at its last value outside DONE.

Reset
REQ-026 SHALL, on rst, enter IDLE and drive in_ready=1, out_valid=0, busy=0, result_o=0, accumulator=0, iteration counter=0.
REQ-027 SHALL, on rst mid-BUSY or in DONE, discard the operation and produce no out_valid.

Configuration
REQ-028 SHALL, with SEQ_MAC_ACC_EN defined, implement the accumulator, acc_i, and acc_clr per REQ-023/024.
REQ-029 SHALL, without SEQ_MAC_ACC_EN, keep acc_i/acc_clr as ignored ports, output pure products, and synthesize no accumulator register.

Structure
REQ-030 SHALL place in package seq_mac_pkg: mode enum (MODE_UU, MODE_SU, MODE_SS), FSM state enum (IDLE, BUSY, DONE), and Booth digit enum.
REQ-031 SHALL place the Booth recoding (3 bits → digit select/negate) in sub-module booth_r4_enc, which is purely combinational.

Verification (WIDTH=16)
REQ-032 SHALL cover: SS a=0xFFFD(−3), b=0x0007 → result_o=0xFFFFFFEB, out_valid 10 cycles after acceptance.
REQ-033 SHALL cover: UU a=0xFFFF, b=0xFFFF → 0xFFFE0001; SS same operands → 0x00000001; SU a=0xFFFF, b=0xFFFF → 0xFFFF0001.
REQ-034 SHALL cover: SS a=0x8000, b=0x8000 → 0x40000000.
REQ-035 SHALL cover: out_ready low 5 cycles in DONE → result_o/out_valid stable, in_ready low, new in_valid ignored.
REQ-036 SHALL cover: ACC_EN, acc_clr, then 3×4 and 5×6 with acc_i=1 → results 12 then 42; without the macro → 12 then 30.
REQ-037 SHALL cover: rst asserted 3 cycles into BUSY → IDLE next cycle, no out_valid, next 2×2 → 4.

Source files
------------

// File: rtl/seq_mac_pkg.sv
// seq_mac_pkg: shared types for the sequential radix-4 Booth multiply-accumulate.
//   mode_e        operand signedness selection
//   state_e       control FSM states
//   booth_digit_e recoded radix-4 Booth digit (-2..+2)
package seq_mac_pkg;

    localparam int unsigned BOOTH_BITS = 3;

    typedef enum logic [1:0] {
        MODE_UU = 2'b00,
        MODE_SU = 2'b01,
        MODE_SS = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef enum logic [2:0] {
        DIG_ZERO = 3'd0,
        DIG_POS1 = 3'd1,
        DIG_POS2 = 3'd2,
        DIG_NEG1 = 3'd3,
        DIG_NEG2 = 3'd4
    } booth_digit_e;

    // Multiplicand is signed for every mode except unsigned x unsigned.
    function automatic logic mode_a_signed(input logic [1:0] mode);
        return (mode != MODE_UU);
    endfunction

    // Multiplier is signed for signed x signed and for the reserved code 11.
    function automatic logic mode_b_signed(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/seq_mac_booth.sv
// booth_r4_enc: combinational radix-4 Booth recoder.
//   bits_i  [2:0] {b[2i+1], b[2i], b[2i-1]} multiplier window
//   digit_c       recoded digit selecting 0, +-a or +-2a
module booth_r4_enc
    import seq_mac_pkg::*;
(
    input  logic [BOOTH_BITS-1:0] bits_i,
    output booth_digit_e          digit_c
);

    // Standard radix-4 table: value = -2*b2 + b1 + b0.
    always_comb begin
        digit_c = DIG_ZERO;
        case (bits_i)
            3'b001, 3'b010: digit_c = DIG_POS1;
            3'b011:         digit_c = DIG_POS2;
            3'b100:         digit_c = DIG_NEG2;
            3'b101, 3'b110: digit_c = DIG_NEG1;
            default:        digit_c = DIG_ZERO;
        endcase
    end

endmodule

// File: rtl/seq_mac.sv
// seq_mac: sequential radix-4 Booth multiplier with optional accumulator.
// Retires one Booth digit per BUSY cycle; one extra BUSY cycle folds in the
// accumulator, so out_valid rises STEPS+1 cycles after acceptance.
// Optional feature: define SEQ_MAC_ACC_EN to build the accumulator.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (ready only in IDLE)
//   a_i, b_i, mode_i    operands and signedness mode
//   acc_i, acc_clr      accumulate request / accumulator clear
//   result_o            product or accumulated sum, held outside DONE
//   out_valid/out_ready result handshake (valid only in DONE)
//   busy                high while iterating
module seq_mac
    import seq_mac_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [1:0]         mode_i,
    input  logic               acc_i,
    input  logic               acc_clr,
    output logic [2*WIDTH-1:0] result_o,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    localparam int unsigned STEPS = WIDTH / 2 + 1;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned EW    = WIDTH + 2;
    localparam int unsigned CW    = $clog2(STEPS + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] mcand_q;
    logic [PW-1:0] prod_q;
    logic [PW-1:0] term_c;
    logic [EW-1:0] mplier_q;
    logic          prev_q;
    booth_digit_e  digit_c;
    logic          accept_c;
    logic          last_c;
    logic          finish_c;
    logic          a_sign_c;
    logic          b_sign_c;

    assign accept_c = in_valid && in_ready;
    assign last_c   = (cnt_q == CW'(STEPS));
    assign finish_c = (state_q == BUSY) && last_c;
    assign a_sign_c = mode_a_signed(mode_i) & a_i[WIDTH-1];
    assign b_sign_c = mode_b_signed(mode_i) & b_i[WIDTH-1];

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c)  state_d = BUSY;
            BUSY:    if (last_c)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            busy      <= (state_d == BUSY);
        end
    end

    booth_r4_enc u_enc (
        .bits_i  ({mplier_q[1:0], prev_q}),
        .digit_c (digit_c)
    );

    // Partial product for the current digit; all arithmetic is mod 2^PW.
    always_comb begin
        term_c = '0;
        case (digit_c)
            DIG_POS1: term_c = mcand_q;
            DIG_POS2: term_c = mcand_q << 1;
            DIG_NEG1: term_c = '0 - mcand_q;
            DIG_NEG2: term_c = '0 - (mcand_q << 1);
            default:  term_c = '0;
        endcase
    end

    // Iteration datapath: multiplicand walks left, multiplier walks right.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prev_q   <= 1'b0;
            prod_q   <= '0;
        end else if (accept_c) begin
            cnt_q    <= '0;
            mcand_q  <= {{(PW - WIDTH){a_sign_c}}, a_i};
            mplier_q <= {{2{b_sign_c}}, b_i};
            prev_q   <= 1'b0;
            prod_q   <= '0;
        end else if ((state_q == BUSY) && !last_c) begin
            cnt_q    <= cnt_q + CW'(1);
            mcand_q  <= mcand_q << 2;
            mplier_q <= mplier_q >> 2;
            prev_q   <= mplier_q[1];
            prod_q   <= prod_q + term_c;
        end
    end

`ifdef SEQ_MAC_ACC_EN
    logic [PW-1:0] acc_q;
    logic [PW-1:0] sum_c;
    logic          acc_l_q;

    assign sum_c = acc_l_q ? (acc_q + prod_q) : prod_q;

    // Result and accumulator; a clear wins over a same-cycle update.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            acc_l_q  <= 1'b0;
            result_o <= '0;
        end else begin
            if (accept_c) acc_l_q <= acc_i;
            if (finish_c) result_o <= sum_c;
            if (acc_clr) begin
                acc_q <= '0;
            end else if (finish_c && acc_l_q) begin
                acc_q <= sum_c;
            end
        end
    end
`else
    logic unused_acc;
    assign unused_acc = acc_i ^ acc_clr;

    // Result register: plain product.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_o <= '0;
        end else if (finish_c) begin
            result_o <= prod_q;
        end
    end
`endif

endmodule

// File: tb/tb_seq_mac.sv
// tb_seq_mac: directed and randomized checks of seq_mac (WIDTH=16) against
// an arithmetic reference model.
module tb_seq_mac;

    localparam int unsigned WIDTH = 16;
    localparam int          STEPS = WIDTH / 2 + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a_i;
    logic [WIDTH-1:0]  b_i;
    logic [1:0]        mode_i;
    logic              acc_i;
    logic              acc_clr;
    logic [2*WIDTH-1:0] result_o;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] acc_m  = '0;

    seq_mac #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .mode_i    (mode_i),
        .acc_i     (acc_i),
        .acc_clr   (acc_clr),
        .result_o  (result_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: interpret operands per mode, multiply exactly, keep 32 bits.
    function automatic logic [31:0] model_prod(input logic [15:0] a, input logic [15:0] b,
                                               input logic [1:0] mode);
        longint av;
        longint bv;
        av = (mode == 2'b00) ? longint'(a) : longint'($signed(a));
        bv = mode[1] ? longint'($signed(b)) : longint'(b);
        return 32'(av * bv);
    endfunction

    // One full transaction; hold = cycles to keep out_ready low in DONE.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] mode,
                          input logic acc, input logic clr, input int hold, input string tag);
        logic [31:0] exp;
        int          n;
        exp = model_prod(a, b, mode);
`ifdef SEQ_MAC_ACC_EN
        if (clr) acc_m = '0;
        if (acc) begin
            exp   = acc_m + exp;
            acc_m = exp;
        end
`endif
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, " in_ready"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        a_i      = a;
        b_i      = b;
        mode_i   = mode;
        acc_i    = acc;
        acc_clr  = clr;
        tick();
        // Scramble inputs after acceptance; they must have no effect.
        in_valid = 1'b0;
        acc_clr  = 1'b0;
        a_i      = 16'($urandom);
        b_i      = 16'($urandom);
        mode_i   = 2'($urandom);
        acc_i    = 1'($urandom);
        check({tag, " busy"}, 64'(busy), 64'(1));
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(STEPS + 1));
        check({tag, " result"}, 64'(result_o), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a_i      = 16'($urandom);
            b_i      = 16'($urandom);
            tick();
            check({tag, " hold valid"}, 64'(out_valid), 64'(1));
            check({tag, " hold result"}, 64'(result_o), 64'(exp));
            check({tag, " hold in_ready"}, 64'(in_ready), 64'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " exit in_ready"}, 64'(in_ready), 64'(1));
        check({tag, " exit out_valid"}, 64'(out_valid), 64'(0));
        check({tag, " exit busy"}, 64'(busy), 64'(0));
        check({tag, " exit held"}, 64'(result_o), 64'(exp));
    endtask

    initial begin
        int          seen;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] pick [5];

        rst       = 1'b1;
        in_valid  = 1'b0;
        a_i       = '0;
        b_i       = '0;
        mode_i    = 2'b00;
        acc_i     = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset in_ready", 64'(in_ready), 64'(1));
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset result", 64'(result_o), 64'(0));

        // Directed operand corners.
        run_op(16'hFFFD, 16'h0007, 2'b10, 1'b0, 1'b0, 0, "ss_m3x7");
        run_op(16'hFFFF, 16'hFFFF, 2'b00, 1'b0, 1'b0, 0, "uu_ffff");
        run_op(16'hFFFF, 16'hFFFF, 2'b10, 1'b0, 1'b0, 0, "ss_ffff");
        run_op(16'hFFFF, 16'hFFFF, 2'b01, 1'b0, 1'b0, 0, "su_ffff");
        run_op(16'h8000, 16'h8000, 2'b10, 1'b0, 1'b0, 0, "ss_8000");
        run_op(16'h8000, 16'h7FFF, 2'b11, 1'b0, 1'b0, 0, "rsv_mode");

        // Output held while the consumer stalls.
        run_op(16'h1234, 16'hABCD, 2'b01, 1'b0, 1'b0, 5, "stall");

        // Accumulation sequence: 12 then 42 (or 30 without accumulator).
        run_op(16'd3, 16'd4, 2'b00, 1'b1, 1'b1, 0, "acc_3x4");
        run_op(16'd5, 16'd6, 2'b00, 1'b1, 1'b0, 0, "acc_5x6");

        // Reset in the middle of an operation.
        in_valid = 1'b1;
        a_i      = 16'd5;
        b_i      = 16'd5;
        mode_i   = 2'b00;
        acc_i    = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        acc_m = '0;
        check("midrst in_ready", 64'(in_ready), 64'(1));
        check("midrst busy", 64'(busy), 64'(0));
        check("midrst out_valid", 64'(out_valid), 64'(0));
        check("midrst result", 64'(result_o), 64'(0));
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen = 1;
        end
        check("midrst no out_valid", 64'(seen), 64'(0));
        run_op(16'd2, 16'd2, 2'b00, 1'b0, 1'b0, 0, "rst_2x2");

        // Randomized operations biased toward boundary operands.
        pick[0] = 16'h8000;
        pick[1] = 16'hFFFF;
        pick[2] = 16'h0000;
        pick[3] = 16'h7FFF;
        for (int k = 0; k < 30; k++) begin
            pick[4] = 16'($urandom);
            ra = pick[$urandom_range(0, 4)];
            pick[4] = 16'($urandom);
            rb = pick[$urandom_range(0, 4)];
            run_op(ra, rb, 2'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                   int'($urandom_range(0, 2)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
